// File: rtl/kb_input_port.sv
// Keyboard input port: synchronizes a key strobe, queues key codes in a small FIFO and presents the head to the core.
// Define KB_OVERRUN_STICKY_EN to make kb_overrun a sticky flag cleared by kb_ovr_clr; otherwise it is a one-cycle pulse.
module kb_input_port #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        key_code,
   input  logic                     key_strobe,
   input  logic                     kb_rd,
   input  logic                     kb_ovr_clr,
   output logic [DATA_W-1:0]        KB_input,
   output logic                     kb_ready,
   output logic [$clog2(DEPTH):0]   kb_count,
   output logic                     kb_overrun
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              ready_q, ready_d;
   logic              ovr_q, ovr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic push_evt, is_empty, is_full, do_push, do_pop, drop;

   always_comb begin
      s1_d     = key_strobe;
      s2_d     = s1_q;
      s3_d     = s2_q;
      push_evt = s2_q & ~s3_q;
      is_empty = (count_q == '0);
      is_full  = (count_q == FULL_COUNT);
      do_pop   = kb_rd & ~is_empty;
      // A full FIFO still accepts a push when the same cycle frees a slot.
      do_push  = push_evt & (~is_full | do_pop);
      drop     = push_evt & is_full & ~do_pop;

      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // The new head may be the code being written this very edge.
      if (count_d == '0)
         head_d = '0;
      else if (do_push && (rd_ptr_d == wr_ptr_q))
         head_d = key_code;
      else
         head_d = mem_q[rd_ptr_d];

      ready_d = (count_d != '0);

`ifdef KB_OVERRUN_STICKY_EN
      if (drop)
         ovr_d = 1'b1;
      else if (kb_ovr_clr)
         ovr_d = 1'b0;
      else
         ovr_d = ovr_q;
`else
      ovr_d = drop;
`endif
   end

`ifndef KB_OVERRUN_STICKY_EN
   logic ovr_clr_unused;
   assign ovr_clr_unused = kb_ovr_clr;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         ready_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         ready_q  <= ready_d;
         ovr_q    <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= key_code;
   end

   assign KB_input   = head_q;
   assign kb_ready   = ready_q;
   assign kb_count   = count_q;
   assign kb_overrun = ovr_q;

endmodule

// File: tb/tb_kb_input_port.sv
// Directed self-checking bench for kb_input_port (default 4-entry FIFO; overrun checks follow KB_OVERRUN_STICKY_EN).
module tb_kb_input_port;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_code;
   logic       key_strobe;
   logic       kb_rd;
   logic       kb_ovr_clr;
   logic [7:0] KB_input;
   logic       kb_ready;
   logic [2:0] kb_count;
   logic       kb_overrun;

   int checks = 0;
   int errors = 0;

   kb_input_port #(.DATA_W(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_strobe (key_strobe),
      .kb_rd      (kb_rd),
      .kb_ovr_clr (kb_ovr_clr),
      .KB_input   (KB_input),
      .kb_ready   (kb_ready),
      .kb_count   (kb_count),
      .kb_overrun (kb_overrun)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe rising edge: the push lands on the third edge, then the synchronizer settles low.
   task automatic push_key(input logic [7:0] code);
      key_code   = code;
      key_strobe = 1'b1;
      repeat (3) tick();
      key_strobe = 1'b0;
      repeat (3) tick();
   endtask

   task automatic pop_one();
      kb_rd = 1'b1;
      tick();
      kb_rd = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         key_strobe = ~key_strobe;
         key_code   = 8'(8'hA0 + i);
         tick();
      end
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL reset_head: got %h expected 00", KB_input); end
      checks++; if (kb_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", kb_ready); end
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", kb_count); end
      checks++; if (kb_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr: got %b expected 0", kb_overrun); end
      key_strobe = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      key_code   = 8'h20;
      key_strobe = 1'b1;
      tick();
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL latency_k: got %0d expected 0", kb_count); end
      tick();
      checks++; if (kb_ready !== 1'b0) begin errors++; $display("[TB] FAIL latency_k1: got %b expected 0", kb_ready); end
      tick();
      checks++; if (KB_input !== 8'h20) begin errors++; $display("[TB] FAIL latency_head: got %h expected 20", KB_input); end
      checks++; if (kb_ready !== 1'b1) begin errors++; $display("[TB] FAIL latency_ready: got %b expected 1", kb_ready); end
      checks++; if (kb_count !== 3'd1) begin errors++; $display("[TB] FAIL latency_count: got %0d expected 1", kb_count); end
      key_strobe = 1'b0;
      repeat (3) tick();
      pop_one();
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL first_pop_count: got %0d expected 0", kb_count); end
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL first_pop_head: got %h expected 00", KB_input); end
   endtask

   task automatic test_order_wrap();
      logic [7:0] tail [4];
      tail = '{8'h33, 8'h44, 8'h55, 8'h66};
      push_key(8'h11);
      push_key(8'h22);
      push_key(8'h33);
      push_key(8'h44);
      checks++; if (kb_count !== 3'd4) begin errors++; $display("[TB] FAIL order_fill: got %0d expected 4", kb_count); end
      checks++; if (KB_input !== 8'h11) begin errors++; $display("[TB] FAIL order_head0: got %h expected 11", KB_input); end
      pop_one();
      checks++; if (KB_input !== 8'h22) begin errors++; $display("[TB] FAIL order_head1: got %h expected 22", KB_input); end
      pop_one();
      push_key(8'h55);
      push_key(8'h66);
      checks++; if (kb_count !== 3'd4) begin errors++; $display("[TB] FAIL order_refill: got %0d expected 4", kb_count); end
      // Pop back to back, one per cycle.
      kb_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (KB_input !== tail[i]) begin errors++; $display("[TB] FAIL order_read%0d: got %h expected %h", i, KB_input, tail[i]); end
         tick();
      end
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL order_empty: got %0d expected 0", kb_count); end
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL order_empty_head: got %h expected 00", KB_input); end
   endtask

   task automatic test_overrun();
      logic [7:0] fill [4];
      fill = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int i = 0; i < 4; i++) push_key(fill[i]);
      key_code   = 8'h99;
      key_strobe = 1'b1;
      repeat (3) tick();
      checks++; if (kb_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", kb_overrun); end
      checks++; if (kb_count !== 3'd4) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 4", kb_count); end
      key_strobe = 1'b0;
      tick();
`ifdef KB_OVERRUN_STICKY_EN
      checks++; if (kb_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", kb_overrun); end
      kb_ovr_clr = 1'b1;
      tick();
      kb_ovr_clr = 1'b0;
      checks++; if (kb_overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", kb_overrun); end
`else
      checks++; if (kb_overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_pulse: got %b expected 0", kb_overrun); end
`endif
      repeat (2) tick();
      kb_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (KB_input !== fill[i]) begin errors++; $display("[TB] FAIL ovr_read%0d: got %h expected %h", i, KB_input, fill[i]); end
         tick();
      end
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL ovr_drain: got %0d expected 0", kb_count); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] expect_q [4];
      expect_q = '{8'hB2, 8'hB3, 8'hB4, 8'h77};
      push_key(8'hB1);
      push_key(8'hB2);
      push_key(8'hB3);
      push_key(8'hB4);
      key_code   = 8'h77;
      key_strobe = 1'b1;
      repeat (2) tick();
      kb_rd = 1'b1;
      tick();
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_count: got %0d expected 4", kb_count); end
      checks++; if (kb_overrun !== 1'b0) begin errors++; $display("[TB] FAIL fpp_ovr: got %b expected 0", kb_overrun); end
      key_strobe = 1'b0;
      repeat (3) tick();
      kb_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (KB_input !== expect_q[i]) begin errors++; $display("[TB] FAIL fpp_read%0d: got %h expected %h", i, KB_input, expect_q[i]); end
         tick();
      end
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL fpp_drain: got %0d expected 0", kb_count); end
   endtask

   task automatic test_empty();
      kb_rd = 1'b1;
      repeat (3) tick();
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL empty_rd_count: got %0d expected 0", kb_count); end
      checks++; if (kb_ready !== 1'b0) begin errors++; $display("[TB] FAIL empty_rd_ready: got %b expected 0", kb_ready); end
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL empty_rd_head: got %h expected 00", KB_input); end
      key_code   = 8'h5A;
      key_strobe = 1'b1;
      repeat (2) tick();
      kb_rd = 1'b1;
      tick();
      kb_rd = 1'b0;
      checks++; if (kb_count !== 3'd1) begin errors++; $display("[TB] FAIL empty_pp_count: got %0d expected 1", kb_count); end
      checks++; if (KB_input !== 8'h5A) begin errors++; $display("[TB] FAIL empty_pp_head: got %h expected 5a", KB_input); end
      checks++; if (kb_ready !== 1'b1) begin errors++; $display("[TB] FAIL empty_pp_ready: got %b expected 1", kb_ready); end
      key_strobe = 1'b0;
      repeat (3) tick();
      pop_one();
   endtask

   task automatic test_held_strobe_reset();
      int max_cnt;
      max_cnt    = 0;
      key_code   = 8'h3C;
      key_strobe = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (int'(kb_count) > max_cnt) max_cnt = int'(kb_count);
      end
      key_strobe = 1'b0;
      repeat (3) tick();
      checks++; if (max_cnt != 1) begin errors++; $display("[TB] FAIL held_max: got %0d expected 1", max_cnt); end
      checks++; if (kb_count !== 3'd1) begin errors++; $display("[TB] FAIL held_count: got %0d expected 1", kb_count); end
      push_key(8'h3D);
      push_key(8'h3E);
      checks++; if (kb_count !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_count: got %0d expected 3", kb_count); end
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_head: got %h expected 00", KB_input); end
      checks++; if (kb_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", kb_ready); end
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", kb_count); end
      checks++; if (kb_overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ovr: got %b expected 0", kb_overrun); end
      repeat (2) tick();
      rst = 1'b1;
      repeat (4) tick();
      checks++; if (kb_count !== 3'd0) begin errors++; $display("[TB] FAIL post_reset_count: got %0d expected 0", kb_count); end
      checks++; if (KB_input !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_head: got %h expected 00", KB_input); end
      push_key(8'h42);
      checks++; if (KB_input !== 8'h42) begin errors++; $display("[TB] FAIL post_reset_push: got %h expected 42", KB_input); end
      checks++; if (kb_count !== 3'd1) begin errors++; $display("[TB] FAIL post_reset_push_count: got %0d expected 1", kb_count); end
   endtask

   initial begin
      rst        = 1'b0;
      key_code   = 8'h00;
      key_strobe = 1'b0;
      kb_rd      = 1'b0;
      kb_ovr_clr = 1'b0;
      test_reset();
      test_order_wrap();
      test_overrun();
      test_full_push_pop();
      test_empty();
      test_held_strobe_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kb_input_port.md
# kb_input_port

Keyboard-side input port feeding the `MCU` `KB_input` bus. It synchronizes an asynchronous key strobe, captures the accompanying 8-bit key code into a small FIFO, and presents the oldest entry to the core. The core pops the entry by pulsing a read strobe when it consumes `KB_input`. This block is the producer for the core's keyboard read path and sits between board key logic and `MCU`.

## Interface
- `DATA_W`, 8, key code width; matches `KB_input`.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `key_code`  in  DATA_W  raw key code; stable ≥4 cycles after `key_strobe` rises.
- `key_strobe`  in  1  asynchronous key-press strobe; a rising edge means one key event.
- `kb_rd`  in  1  pop request from the core, one cycle per consumed code.
- `kb_ovr_clr`  in  1  clears `kb_overrun` (sticky mode only).
- `KB_input`  out  DATA_W  head of FIFO; 0 when empty.
- `kb_ready`  out  1  FIFO not empty.
- `kb_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `kb_overrun`  out  1  a key event was dropped because the FIFO was full.

## Operation
- Strobe path: 2-flop synchronizer (`s1`, `s2`) followed by a history flop `s3`. The push condition is `s2 & ~s3`, so exactly one push occurs per rising edge. Level-high holds do not repeat.
- Push: `key_code` is written at `wr_ptr` and `wr_ptr` increments modulo DEPTH.
- Pop: when `kb_rd` is high and the FIFO is not empty, `rd_ptr` increments modulo DEPTH. `kb_rd` on an empty FIFO is ignored, with no pointer or count change.
- Occupancy counter updates:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
  - neither: hold
- Full, push, no pop: the code is dropped, pointers and count hold, and the overrun event fires.
- Full, push and pop in the same cycle: both take effect, the count stays DEPTH, and there is no overrun.
- Empty, push and pop in the same cycle: the pop is ignored and the push takes effect, giving count 1.
- `KB_input` is a registered head value. It equals `mem[rd_ptr]` when count > 0 and 0 otherwise. It updates on the same edge as the push or pop that changes the head.
- `kb_ready` = (`kb_count` != 0), registered in step with `kb_count`.

## Timing
- Reset (`rst` low, asynchronous): `s1`, `s2`, `s3`, pointers, count, `kb_overrun` and `KB_input` all go to 0, so `kb_ready` is 0. FIFO memory contents are don't-care.
- If reset asserts mid-operation, all queued codes are discarded immediately. There is no partial push after reset releases.
- Strobe latency: with `key_strobe` rising before edge k, `s1`=1 after k and `s2`=1 after k+1. The push occurs at edge k+2, so `KB_input`/`kb_ready` are valid after edge k+2.
- `key_code` is sampled at the push edge, hence the stability requirement of ≥4 cycles.
- Pop latency: with `kb_rd` high in cycle n, the next entry (or 0) appears after edge n. The core may pop every cycle.
- Pointer wrap: DEPTH−1 → 0. No off-by-one is allowed at wrap; count and pointers are independent.

## Configuration
- `KB_OVERRUN_STICKY_EN` defined:
  - `kb_overrun` sets on a dropped push and stays 1 until `kb_ovr_clr` is high at a clock edge.
  - A set and a clear in the same cycle leave the flag at 1.
- `KB_OVERRUN_STICKY_EN` undefined:
  - `kb_overrun` is a registered one-cycle pulse on each dropped push.
  - `kb_ovr_clr` is ignored.

## Test plan
- Reset: hold `rst`=0 with strobes toggling. Required: all outputs 0. Release, send one strobe with code 0x20. Required: `KB_input`=0x20, `kb_ready`=1, `kb_count`=1 exactly 2 edges after the first synchronizer sample.
- Order and wrap: push 0x11, 0x22, 0x33, 0x44, pop two, push 0x55, 0x66, then pop all. Required: read order 11,22,33,44,55,66 and `kb_count` returns to 0.
- Overrun: fill with DEPTH=4 codes, push 0x99. Required: 0x99 is not stored and the count stays 4.
  - Sticky build: `kb_overrun`=1 until a `kb_ovr_clr` pulse.
  - Non-sticky build: a single-cycle pulse.
- Full with simultaneous push and pop: the push edge of 0x77 coincides with `kb_rd`. Required: count stays 4, no overrun, and 0x77 emerges last.
- Empty edge cases:
  - `kb_rd` pulses on an empty FIFO: no change.
  - Empty with push and `kb_rd` in the same cycle: count becomes 1 and `KB_input` equals the pushed code.
- Held strobe plus mid-run reset:
  - `key_strobe` held high for 50 cycles: exactly one push.
  - With 3 entries queued, assert `rst` mid-cycle: all outputs 0 immediately, and the FIFO is empty after release.
